// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
//
// Shared types for the 5-stage MIPS pipeline.
//   word_t         - 32-bit machine word / address
//   opcode_t       - 6-bit primary opcode field (instr[31:26])
//   HALT           - opcode that stops instruction fetch
//   fetch_state_t  - fetch stage FSM states (IDLE, FETCH, HOLD, HALTED)
// Helper functions:
//   align_word()   - clears the byte-offset bits of an address
//   is_halt()      - true when an instruction word carries the HALT opcode
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;

    localparam opcode_t HALT = 6'b111111;

    // Fixed encodings so that older netlists and waveform scripts that refer
    // to the raw two-bit state values keep working.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        FETCH  = ST_FETCH,
        HOLD   = ST_HOLD,
        HALTED = ST_HALTED
    } fetch_state_t;

    // Instruction addresses are always word aligned; the low two bits of any
    // externally supplied target are simply dropped.
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_halt(input word_t instr);
        return (instr[31:26] == HALT);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, talks to
// instruction memory with a hold-until-hit request handshake and produces the
// write/flush controls and payload for the IF/ID pipeline register.
//
// Ports:
//   CLK            in   rising-edge clock
//   nRST           in   asynchronous active-low reset
//   imemREN        out  instruction read request
//   imemaddr       out  word-aligned request address (== pc while requesting)
//   ihit           in   imemload is valid for the current request
//   imemload       in   instruction word returned by memory
//   stall          in   decode/hazard stall, IF/ID must hold
//   redirect       in   taken branch/jump from a later stage
//   redirect_addr  in   redirect target (low two bits ignored)
//   ifW            out  IF/ID write enable
//   ifRST          out  IF/ID flush (writes a bubble when ifW=1)
//   ifinstr        out  instruction presented to IF/ID
//   ifJALjump_addr out  PC+4 of the presented instruction (JAL link value)
//   fetch_halted   out  a HALT has been fetched and fetching has stopped
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        ifW,
    output logic        ifRST,
    output logic [31:0] ifinstr,
    output logic [31:0] ifJALjump_addr,
    output logic        fetch_halted
);

    fetch_state_t state, state_n;

    // pc is the address of the request in flight (or the next one to issue).
    // While a redirect arrives mid-request, the target is parked in tgt and
    // drop_pend marks the returning word as wrong-path so the address seen by
    // memory never changes before ihit.
    word_t pc, pc_n;
    word_t tgt, tgt_n;
    logic  drop_pend, drop_pend_n;

    // A word that hit while decode was stalled is parked here until IF/ID
    // can accept it, so memory is never asked for the same word twice.
    word_t hold_instr, hold_instr_n;
    word_t hold_npc, hold_npc_n;

    word_t pc_plus4;
    word_t redir_tgt;
    logic  fetching;
    logic  deliver_fetch;
    logic  deliver_hold;
    logic  valid;

    assign pc_plus4  = pc + 32'd4;
    assign redir_tgt = align_word(redirect_addr);
    assign fetching  = (state == FETCH);

    // A fresh word goes straight to IF/ID only when nothing outranks it:
    // redirect first, then a wrong-path drop, then the decode stall.
    assign deliver_fetch = fetching && ihit && !redirect && !drop_pend && !stall;
    assign deliver_hold  = (state == HOLD) && !redirect && !stall;
    assign valid         = deliver_fetch || deliver_hold;

    // Output decode. Everything is forced low while nRST is asserted so the
    // IF/ID register sees no write and memory sees no request during reset,
    // even in the cycle the reset lands mid-request.
    always_comb begin
        imemREN        = 1'b0;
        imemaddr       = '0;
        ifW            = 1'b0;
        ifRST          = 1'b0;
        ifinstr        = '0;
        ifJALjump_addr = '0;
        fetch_halted   = 1'b0;
        if (nRST) begin
            imemREN      = fetching;
            imemaddr     = fetching ? pc : '0;
            ifW          = redirect || !stall;
            ifRST        = redirect || !valid;
            fetch_halted = (state == HALTED);
            if (deliver_fetch) begin
                ifinstr        = imemload;
                ifJALjump_addr = pc_plus4;
            end else if (deliver_hold) begin
                ifinstr        = hold_instr;
                ifJALjump_addr = hold_npc;
            end
        end
    end

    // Next-state logic for the FSM, the PC and the parked redirect / held
    // instruction registers.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        tgt_n        = tgt;
        drop_pend_n  = drop_pend;
        hold_instr_n = hold_instr;
        hold_npc_n   = hold_npc;

        case (state)
            IDLE: begin
                state_n = FETCH;
                if (redirect) begin
                    pc_n = redir_tgt;
                end
            end

            FETCH: begin
                if (redirect) begin
                    if (ihit) begin
                        // Request completes this cycle: the word is wrong-path
                        // and the new target can be issued next cycle.
                        pc_n        = redir_tgt;
                        drop_pend_n = 1'b0;
                    end else begin
                        // Request still open: keep the address stable and
                        // remember where to go once it finally hits.
                        tgt_n       = redir_tgt;
                        drop_pend_n = 1'b1;
                    end
                end else if (ihit) begin
                    if (drop_pend) begin
                        pc_n        = tgt;
                        drop_pend_n = 1'b0;
                    end else if (stall) begin
                        hold_instr_n = imemload;
                        hold_npc_n   = pc_plus4;
                        pc_n         = pc_plus4;
                        state_n      = HOLD;
                    end else begin
                        pc_n = pc_plus4;
                        if (is_halt(imemload)) begin
                            state_n = HALTED;
                        end
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_n    = redir_tgt;
                    state_n = FETCH;
                end else if (!stall) begin
                    state_n = is_halt(hold_instr) ? HALTED : FETCH;
                end
            end

            HALTED: begin
                // A redirect means the HALT sat on a wrong path.
                if (redirect) begin
                    pc_n    = redir_tgt;
                    state_n = FETCH;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset abandons any request in flight;
    // whatever memory returns afterwards is ignored because the FSM restarts
    // from IDLE and does not look at ihit there.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            pc         <= PC_INIT;
            tgt        <= '0;
            drop_pend  <= 1'b0;
            hold_instr <= '0;
            hold_npc   <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            tgt        <= tgt_n;
            drop_pend  <= drop_pend_n;
            hold_instr <= hold_instr_n;
            hold_npc   <= hold_npc_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. Inputs are applied just after the
// falling clock edge, outputs are compared 1 ns later against a behavioural
// model of the fetch stage, and the model advances before the next rising
// edge. A directed sequence walks the listed scenarios, then randomized
// traffic (stalls, redirects, slow memory, occasional resets) follows.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        ifW;
    logic        ifRST;
    logic [31:0] ifinstr;
    logic [31:0] ifJALjump_addr;
    logic        fetch_halted;

    int total = 0;
    int bad   = 0;

    // Reference model: where the fetch stage is in its life and what it owes.
    bit          m_started;
    bit          m_halted;
    bit          m_held;
    logic [31:0] m_held_instr;
    logic [31:0] m_held_link;
    logic [31:0] m_pc;
    bit          m_wrong_path;
    logic [31:0] m_after_wrong_path;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .imemREN        (imemREN),
        .imemaddr       (imemaddr),
        .ihit           (ihit),
        .imemload       (imemload),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_addr  (redirect_addr),
        .ifW            (ifW),
        .ifRST          (ifRST),
        .ifinstr        (ifinstr),
        .ifJALjump_addr (ifJALjump_addr),
        .fetch_halted   (fetch_halted)
    );

    // Instruction memory image: a few fixed words, otherwise a hash of the
    // address with a HALT sprinkled in every so often.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h0)  return 32'h2001_0001;
        if (a == 32'h4)  return 32'h2002_0002;
        if (a == 32'h20) return 32'hFC00_0000;
        h = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        if (((a >> 2) % 29) == 13) return {6'b111111, h[25:0]};
        return {1'b0, h[30:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_started          = 1'b0;
        m_halted           = 1'b0;
        m_held             = 1'b0;
        m_held_instr       = '0;
        m_held_link        = '0;
        m_pc               = 32'h0;
        m_wrong_path       = 1'b0;
        m_after_wrong_path = '0;
    endtask

    // Asserts reset asynchronously, checks every output is quiet, then
    // releases on the next falling edge.
    task automatic applyReset();
        nRST          = 1'b0;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        ihit          = 1'b0;
        imemload      = $urandom();
        #1;
        checkOutput("rst_ren",    {31'b0, imemREN},      32'h0);
        checkOutput("rst_addr",   imemaddr,              32'h0);
        checkOutput("rst_ifW",    {31'b0, ifW},          32'h0);
        checkOutput("rst_ifRST",  {31'b0, ifRST},        32'h0);
        checkOutput("rst_instr",  ifinstr,               32'h0);
        checkOutput("rst_link",   ifJALjump_addr,        32'h0);
        checkOutput("rst_halted", {31'b0, fetch_halted}, 32'h0);
        modelReset();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance it.
    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] ra, input logic h);
        logic        asking;
        logic        delivers;
        logic [31:0] exp_instr;
        logic [31:0] exp_link;
        logic [31:0] target;

        stall         = s;
        redirect      = r;
        redirect_addr = ra;
        ihit          = h;
        imemload      = h ? mem_word(m_pc) : $urandom();
        #1;

        target    = ra & 32'hFFFF_FFFC;
        asking    = m_started && !m_halted && !m_held;
        delivers  = 1'b0;
        exp_instr = '0;
        exp_link  = '0;
        if (asking && h && !r && !m_wrong_path && !s) begin
            delivers  = 1'b1;
            exp_instr = imemload;
            exp_link  = m_pc + 32'd4;
        end else if (m_held && !r && !s) begin
            delivers  = 1'b1;
            exp_instr = m_held_instr;
            exp_link  = m_held_link;
        end

        checkOutput("ren", {31'b0, imemREN}, {31'b0, asking});
        if (asking) checkOutput("addr", imemaddr, m_pc);
        checkOutput("ifW",    {31'b0, ifW},          {31'b0, r | ~s});
        checkOutput("ifRST",  {31'b0, ifRST},        {31'b0, ~delivers});
        checkOutput("instr",  ifinstr,               exp_instr);
        if (delivers) checkOutput("link", ifJALjump_addr, exp_link);
        checkOutput("halted", {31'b0, fetch_halted}, {31'b0, m_halted});

        if (!m_started) begin
            m_started = 1'b1;
            if (r) m_pc = target;
        end else if (m_halted) begin
            if (r) begin
                m_halted = 1'b0;
                m_pc     = target;
            end
        end else if (m_held) begin
            if (r) begin
                m_held = 1'b0;
                m_pc   = target;
            end else if (!s) begin
                m_held   = 1'b0;
                m_halted = (m_held_instr[31:26] == 6'b111111);
            end
        end else if (r) begin
            if (h) begin
                m_pc         = target;
                m_wrong_path = 1'b0;
            end else begin
                m_after_wrong_path = target;
                m_wrong_path       = 1'b1;
            end
        end else if (h) begin
            if (m_wrong_path) begin
                m_pc         = m_after_wrong_path;
                m_wrong_path = 1'b0;
            end else begin
                if (s) begin
                    m_held       = 1'b1;
                    m_held_instr = imemload;
                    m_held_link  = m_pc + 32'd4;
                end else begin
                    m_halted = (imemload[31:26] == 6'b111111);
                end
                m_pc = m_pc + 32'd4;
            end
        end

        @(negedge CLK);
    endtask

    initial begin
        applyReset();

        // Single-cycle memory: IDLE, then 0x0 and 0x4 back to back.
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);

        // Slow memory on 0x0: three bubble cycles, then delivery.
        applyReset();
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);

        // Stall on the hit at 0x8, held for two more cycles, then released.
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);

        // Redirect to 0x40 while 0x10 is outstanding, with stall in the
        // same cycle; 0x10 is dropped when it finally hits.
        applyStimulus(1, 1, 32'h40, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);

        // Jump to 0x18 and run into the HALT at 0x20.
        applyStimulus(0, 1, 32'h18, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);

        // Wrong-path HALT: redirect with unaligned target resumes at 0x80.
        applyStimulus(0, 1, 32'h82, 0);
        applyStimulus(0, 0, 0, 1);

        // Address wrap from 0xFFFFFFFC to 0.
        applyStimulus(0, 1, 32'hFFFF_FFFF, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);

        // Park a redirect on the 0x30 request, then reset mid-request.
        applyStimulus(0, 1, 32'h30, 1);
        applyStimulus(0, 1, 32'h50, 0);
        applyReset();
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);

        // Randomized traffic.
        applyReset();
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if (($urandom() % 400) == 0) begin
                applyReset();
                applyStimulus(0, 0, 0, 0);
            end else begin
                applyStimulus(($urandom() % 4) == 0,
                              ($urandom() % 10) == 0,
                              $urandom() & 32'h3FF,
                              ($urandom() % 3) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; producer side of the IF/ID register.
- Owns the PC and issues requests to instruction memory/icache using a hold-until-hit handshake.
- Drives the IF/ID write-enable (ifW) and flush (ifRST) together with the ifinstr/ifJALjump_addr payload.
- Absorbs decode stalls, branch/jump redirects and HALT.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous reset, active-low.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  instruction address; word aligned.
- ihit  in  1  imemload valid for the current request this cycle.
- imemload  in  32  instruction word returned.
- stall  in  1  decode/hazard stall; IF/ID must hold.
- redirect  in  1  taken branch/jump from a later stage.
- redirect_addr  in  32  redirect target.
- ifW  out  1  IF/ID write enable.
- ifRST  out  1  IF/ID flush; writes a bubble when ifW=1.
- ifinstr  out  32  instruction presented to IF/ID.
- ifJALjump_addr  out  32  PC+4 of the presented instruction (JAL link value).
- fetch_halted  out  1  HALT fetched; fetching stopped.

Behaviour:
- Interface decision: reset nRST, asynchronous, active-low; clock CLK.
- States: IDLE, FETCH, HOLD, HALTED.
- Registers: pc, drop_pend, tgt, hold_instr, hold_npc.
- Reset (async, mid-request included):
  - state=IDLE, pc=PC_INIT, drop_pend=0, hold regs=0.
  - Outstanding request is abandoned; returned data is ignored.
  - Outputs during reset: imemREN=0, ifW=0, ifRST=0, ifinstr=0, ifJALjump_addr=0, fetch_halted=0.
- Output rules:
  - All outputs are combinational from state and registers.
  - ifW = redirect | !stall.
  - ifRST = redirect | !valid, where valid = an instruction is delivered this cycle.
  - When ifRST=1, ifinstr=0.
- Handshake:
  - imemaddr=pc whenever imemREN=1.
  - imemaddr stays stable until ihit, including across a redirect.
  - One outstanding request at most.
- IDLE: imemREN=0, no delivery. Next cycle goes to FETCH.
- FETCH: imemREN=1.
  - redirect & ihit: discard word; pc<=redirect_addr&~3; drop_pend<=0; stay FETCH.
  - redirect & !ihit: tgt<=redirect_addr&~3; drop_pend<=1; address held.
  - ihit & drop_pend: discard word, no delivery; pc<=tgt; drop_pend<=0.
  - ihit & !stall: deliver (valid=1), ifinstr=imemload, ifJALjump_addr=pc+4; pc<=pc+4.
    - If imemload[31:26]==HALT, go to HALTED; the HALT itself is delivered.
  - ihit & stall: hold_instr<=imemload; hold_npc<=pc+4; pc<=pc+4; go to HOLD. No delivery.
  - !ihit: no delivery; a bubble is written if !stall.
- HOLD: imemREN=0; ifinstr=hold_instr; ifJALjump_addr=hold_npc.
  - redirect: flush; pc<=redirect_addr&~3; go to FETCH. Held word is dropped.
  - !stall: deliver held word; go to FETCH, or HALTED if it is a HALT.
  - stall: stay.
- HALTED: imemREN=0; fetch_halted=1; bubbles only.
  - redirect: pc<=redirect_addr&~3; go to FETCH (the HALT was on a wrong path).
- Priority: redirect over stall over delivery.
- Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC wraps to 0). Low 2 bits of the redirect target are forced to 0.
- Latency: with a single-cycle ihit and no stall, one instruction is delivered per cycle; the first is delivered 2 cycles after reset release.

Decomposition:
- cpu_types_pkg (existing): word_t, opcode_t, HALT opcode constant (6'b111111), fetch_state_t enum {IDLE, FETCH, HOLD, HALTED}.
- No sub-module; single flat module. The PC/hold registers and next-state logic fit in one file.

Test Plan:
- Reset release, ihit tied 1, memory holds 0x20010001 at 0x0 and 0x20020002 at 0x4:
  - Cycle 1 is IDLE.
  - Then ifinstr=0x20010001 with ifJALjump_addr=0x4, then 0x20020002 with 0x8.
  - ifW=1, ifRST=0 on each delivery.
- ihit delayed 3 cycles on 0x0: imemaddr stays 0x0 while waiting, ifW=1 and ifRST=1 (bubbles); instruction delivered on the ihit cycle.
- stall=1 on an ihit at 0x8:
  - ifW=0; state goes to HOLD; imemREN=0.
  - Stall held 2 cycles, then released: the held word is delivered with ifJALjump_addr=0xC, then fetch resumes at 0xC.
- redirect to 0x40 while the request at 0x10 is pending (ihit low):
  - ifRST=1; imemaddr stays 0x10 until ihit.
  - The word from 0x10 is discarded; the next request is to 0x40.
  - Redirect with the same-cycle stall=1 still gives ifW=1.
- HALT (0xFC000000) fetched at 0x20: delivered once, fetch_halted=1, imemREN=0, then only bubbles; a later redirect to 0x80 resumes fetching at 0x80.
- nRST asserted mid-request at 0x30 with drop_pend=1: all outputs go to 0 immediately; after release, the first fetch is from PC_INIT.
